rf_fwd_stage: RTL

- Register-fetch/forward (RF/FWD) stage of the SPU pipeline, directly upstream of the fixed-point and other execution units.
- Holds the 128 x 128-bit register file and reads up to three source operands per instruction.
- Bypasses same-cycle writebacks from the even and odd pipes.
- Runs a busy-bit scoreboard that turns RAW/WAW hazards into bubbles with a ready/valid handshake toward decode.
- Outputs are registered and drive the execution unit's op/format/rt_addr/ra/rb/imm/reg_write inputs.

---
 rtl/spu_pkg.sv | 21 ++
 rtl/spu_regfile.sv | 43 ++++
 rtl/rf_fwd_stage.sv | 131 +++++++++++++
 3 files changed

// File: rtl/spu_pkg.sv
// rtl/spu_pkg.sv - shared types and constants for the SPU register-fetch/forward stage
package spu_pkg;

  localparam int NREG  = 128;
  localparam int WIDTH = 128;

  typedef logic [0:6]       reg_addr_t;
  typedef logic [0:WIDTH-1] reg_val_t;
  typedef logic [0:10]      op_t;
  typedef logic [2:0]       fmt_t;
  typedef logic [0:17]      imm_t;

  // format 0 with opcode 0 is the architectural nop
  localparam fmt_t FMT_NOP = 3'd0;
  localparam op_t  OP_NOP  = 11'd0;

  function automatic logic is_nop(input op_t op_v, input fmt_t fmt_v);
    return (op_v == OP_NOP) && (fmt_v == FMT_NOP);
  endfunction

endpackage

// File: rtl/spu_regfile.sv
// rtl/spu_regfile.sv - 128x128 register file, two write ports, three bypassed read ports
module spu_regfile
  import spu_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      we_e_i,
  input  reg_addr_t waddr_e_i,
  input  reg_val_t  wdata_e_i,
  input  logic      we_o_i,
  input  reg_addr_t waddr_o_i,
  input  reg_val_t  wdata_o_i,
  input  reg_addr_t raddr_a_i,
  input  reg_addr_t raddr_b_i,
  input  reg_addr_t raddr_c_i,
  output reg_val_t  rdata_a_o,
  output reg_val_t  rdata_b_o,
  output reg_val_t  rdata_c_o
);

  reg_val_t mem_q [NREG];

  // storage update; the odd write is applied last so it wins on an address collision
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (we_e_i) mem_q[waddr_e_i] <= wdata_e_i;
      if (we_o_i) mem_q[waddr_o_i] <= wdata_o_i;
    end
  end

  // reads see this cycle's writebacks, odd pipe ahead of even pipe
  assign rdata_a_o = (we_o_i && (waddr_o_i == raddr_a_i)) ? wdata_o_i :
                     (we_e_i && (waddr_e_i == raddr_a_i)) ? wdata_e_i : mem_q[raddr_a_i];
  assign rdata_b_o = (we_o_i && (waddr_o_i == raddr_b_i)) ? wdata_o_i :
                     (we_e_i && (waddr_e_i == raddr_b_i)) ? wdata_e_i : mem_q[raddr_b_i];
  assign rdata_c_o = (we_o_i && (waddr_o_i == raddr_c_i)) ? wdata_o_i :
                     (we_e_i && (waddr_e_i == raddr_c_i)) ? wdata_e_i : mem_q[raddr_c_i];

endmodule

// File: rtl/rf_fwd_stage.sv
// rtl/rf_fwd_stage.sv - register fetch with bypass, busy-bit scoreboard and registered issue
module rf_fwd_stage
  import spu_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      in_valid,
  output logic      in_ready,
  input  op_t       op_in,
  input  fmt_t      format_in,
  input  reg_addr_t ra_addr,
  input  reg_addr_t rb_addr,
  input  reg_addr_t rc_addr,
  input  logic [2:0] src_use,
  input  reg_addr_t rt_addr_in,
  input  imm_t      imm_in,
  input  logic      reg_write_in,
  input  reg_val_t  rt_wb_e,
  input  reg_val_t  rt_wb_o,
  input  reg_addr_t rt_addr_wb_e,
  input  reg_addr_t rt_addr_wb_o,
  input  logic      reg_write_wb_e,
  input  logic      reg_write_wb_o,
  output op_t       op,
  output fmt_t      format,
  output reg_addr_t rt_addr,
  output imm_t      imm,
  output logic      reg_write,
  output reg_val_t  ra,
  output reg_val_t  rb,
  output reg_val_t  rc
);

  reg_val_t rd_a, rd_b, rd_c;

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] busy_eff;
  logic            src_busy, dst_busy, hazard, accept, nop_in;

  op_t       op_q;
  fmt_t      format_q;
  reg_addr_t rt_addr_q;
  imm_t      imm_q;
  logic      reg_write_q;
  reg_val_t  ra_q, rb_q, rc_q;

  spu_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we_e_i    (reg_write_wb_e),
    .waddr_e_i (rt_addr_wb_e),
    .wdata_e_i (rt_wb_e),
    .we_o_i    (reg_write_wb_o),
    .waddr_o_i (rt_addr_wb_o),
    .wdata_o_i (rt_wb_o),
    .raddr_a_i (ra_addr),
    .raddr_b_i (rb_addr),
    .raddr_c_i (rc_addr),
    .rdata_a_o (rd_a),
    .rdata_b_o (rd_b),
    .rdata_c_o (rd_c)
  );

  // registers whose busy bit is released by a writeback this cycle
  always_comb begin
    clr_vec = '0;
    if (reg_write_wb_e) clr_vec[rt_addr_wb_e] = 1'b1;
    if (reg_write_wb_o) clr_vec[rt_addr_wb_o] = 1'b1;
  end

  assign busy_eff = busy_q & ~clr_vec;
  assign nop_in   = is_nop(op_in, format_in);

  // RAW on any used source, WAW on the destination
  always_comb begin
    src_busy = (src_use[2] && busy_eff[ra_addr]) ||
               (src_use[1] && busy_eff[rb_addr]) ||
               (src_use[0] && busy_eff[rc_addr]);
    dst_busy = reg_write_in && busy_eff[rt_addr_in];
    hazard   = in_valid && (src_busy || dst_busy);
    accept   = in_valid && !hazard;
  end

  assign in_ready = !hazard;

  // next busy state: releases first, then the accepted destination claim overrides
  always_comb begin
    busy_d = busy_eff;
    if (accept && reg_write_in && !nop_in) busy_d[rt_addr_in] = 1'b1;
  end

  // scoreboard register
  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // issue register: accepted non-nop instructions pass, everything else becomes a zero bubble
  always_ff @(posedge clk) begin
    if (reset || !accept || nop_in) begin
      op_q        <= '0;
      format_q    <= '0;
      rt_addr_q   <= '0;
      imm_q       <= '0;
      reg_write_q <= 1'b0;
      ra_q        <= '0;
      rb_q        <= '0;
      rc_q        <= '0;
    end else begin
      op_q        <= op_in;
      format_q    <= format_in;
      rt_addr_q   <= rt_addr_in;
      imm_q       <= imm_in;
      reg_write_q <= reg_write_in;
      ra_q        <= rd_a;
      rb_q        <= rd_b;
      rc_q        <= rd_c;
    end
  end

  assign op        = op_q;
  assign format    = format_q;
  assign rt_addr   = rt_addr_q;
  assign imm       = imm_q;
  assign reg_write = reg_write_q;
  assign ra        = ra_q;
  assign rb        = rb_q;
  assign rc        = rc_q;

endmodule
